mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM stage, directly downstream of EX via ex_mem. Executes LB/LH/LW/LBU/LHU/SB/SH/SW
//  over a byte-wide RAM port using a multi-cycle FSM and holds the pipeline with stall_o.
//  Non-memory ops pass through combinationally. Results feed mem_wb and ID forwarding.
// PARAMETERS
//  RAM_AW  32  width of ram_addr; mem_addr_i[RAM_AW-1:0] is used and upper bits are ignored
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous reset, active-low (0 = reset)
//  rdy          in   1          global enable; when 0 the block freezes
//  valid_i      in   1          ex_mem holds a live instruction
//  alu_op_i     in   ALU_Len    op code from EX (LB..SW codes, others = non-memory)
//  mem_addr_i   in   32         effective address computed by EX
//  mem_wdata_i  in   32         store data (rs2)
//  rd_data_i    in   32         EX result for non-memory ops
//  rd_addr_i    in   5          destination register
//  rd_enable_i  in   1          destination write enable
//  ram_rdata    in   8          RAM read byte, valid 1 rdy-cycle after its address
//  ram_addr     out  RAM_AW     RAM byte address
//  ram_wdata    out  8          RAM write byte
//  ram_wr       out  1          1 = write ram_wdata to ram_addr this cycle
//  stall_o      out  1          1 = ex_mem and earlier stages must hold
//  valid_o      out  1          result valid for mem_wb this cycle
//  rd_data_o    out  32         writeback/forwarding data
//  rd_addr_o    out  5          writeback register
//  rd_enable_o  out  1          writeback enable
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; idx, latched regs and load buffer = 0; ram_wr=0.
//   All outputs are 0 while in reset.
//  N (byte count) = 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
//  States: IDLE, BUSY (byte idx 0..N-1), WAIT (loads only: capture last byte), DONE.
//  IDLE:
//   - Non-memory op, or valid_i=0: rd_*_o = rd_*_i and valid_o = valid_i, combinationally.
//     stall_o=0 and ram_wr=0.
//   - valid_i=1 and memory op: stall_o=1 and valid_o=0. At the clock edge, latch op, addr,
//     wdata, rd_addr and rd_enable; set idx=0; go to BUSY.
//  BUSY:
//   - stall_o=1, valid_o=0, rd_enable_o=0.
//   - ram_addr = latched_addr + idx, truncated to RAM_AW bits (wraps mod 2^RAM_AW;
//     misaligned accesses are legal).
//   - Store: ram_wr=1 and ram_wdata = wdata[8*idx+7 : 8*idx].
//   - Load: ram_wr=0. If idx>0, capture ram_rdata into buffer byte idx-1.
//   - Transition: if idx=N-1, a store goes to DONE and a load goes to WAIT; otherwise idx++.
//  WAIT:
//   - stall_o=1, ram_wr=0.
//   - Capture ram_rdata into buffer byte N-1, then go to DONE.
//  DONE (exactly 1 cycle):
//   - stall_o=0 and valid_o=1; ex_mem advances on this edge. The held input is NOT
//     re-accepted. Next state is always IDLE.
//   - Load: rd_data_o is the buffer sign-extended (LB, LH) or zero-extended (LBU, LHU);
//     LW uses the buffer unchanged. rd_enable_o = latched rd_enable, rd_addr_o = latched rd.
//   - Store: rd_enable_o=0 and rd_data_o=0.
//  Latency: stall_o is high for N+1 cycles on stores and N+2 cycles on loads (includes
//   the accept cycle). DONE follows. Example: LW gives 6 stall cycles, then 1 DONE cycle.
//  rdy=0: state, idx and buffers hold; ram_wr is forced to 0; no capture; stall_o stays at
//   its current value. ram_rdata is the byte for the last address issued while rdy=1.
//  Reset mid-operation clears the FSM to IDLE immediately. A partially written store is
//   not rolled back.
//  Byte order is little-endian: byte idx maps to data bits [8*idx+7 : 8*idx].
// TESTING
//  1. ADD pass-through, rd_data_i=0x1234, rd=5, valid_i=1 -> same cycle: rd_data_o=0x1234,
//     rd_addr_o=5, valid_o=1, stall_o=0, ram_wr=0.
//  2. SW addr=0x100, wdata=0xAABBCCDD -> ram_wr=1 for 4 cycles with bytes DD,CC,BB,AA at
//     0x100..0x103; 5 stall cycles; DONE with rd_enable_o=0.
//  3. LB addr=0x200, RAM[0x200]=0x80 -> rd_data_o=0xFFFFFF80 in DONE.
//     LBU at the same address -> 0x00000080.
//  4. LH addr=0xFFFFFFFF (RAM_AW=32) -> bytes read from 0xFFFFFFFF and 0x00000000 (wrap);
//     result = {sext, RAM[0], RAM[0xFFFFFFFF]}.
//  5. LW with rdy=0 for 3 cycles mid-BUSY -> no capture or advance while frozen;
//     final data is correct; total stall count = 6 + 3.
//  6. rst=0 asserted during BUSY of an SW -> ram_wr=0 and state IDLE immediately;
//     after release, a new LW completes normally.

Source files
------------

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MEM pipeline stage. Runs byte/half/word loads and stores over
//               a byte-wide RAM port one byte per cycle and stalls upstream.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int                 RAM_AW  = 32,
    parameter int                 ALU_LEN = 5,
    parameter logic [ALU_LEN-1:0] OP_LB   = ALU_LEN'(10),
    parameter logic [ALU_LEN-1:0] OP_LH   = ALU_LEN'(11),
    parameter logic [ALU_LEN-1:0] OP_LW   = ALU_LEN'(12),
    parameter logic [ALU_LEN-1:0] OP_LBU  = ALU_LEN'(13),
    parameter logic [ALU_LEN-1:0] OP_LHU  = ALU_LEN'(14),
    parameter logic [ALU_LEN-1:0] OP_SB   = ALU_LEN'(15),
    parameter logic [ALU_LEN-1:0] OP_SH   = ALU_LEN'(16),
    parameter logic [ALU_LEN-1:0] OP_SW   = ALU_LEN'(17)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               valid_i,
    input  logic [ALU_LEN-1:0] alu_op_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [31:0]        mem_wdata_i,
    input  logic [31:0]        rd_data_i,
    input  logic [4:0]         rd_addr_i,
    input  logic               rd_enable_i,
    input  logic [7:0]         ram_rdata,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [7:0]         ram_wdata,
    output logic               ram_wr,
    output logic               stall_o,
    output logic               valid_o,
    output logic [31:0]        rd_data_o,
    output logic [4:0]         rd_addr_o,
    output logic               rd_enable_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    function automatic logic f_is_load(input logic [ALU_LEN-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic f_is_mem(input logic [ALU_LEN-1:0] op);
        return f_is_load(op) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Index of the final byte of the access (byte count minus one).
    function automatic logic [1:0] f_last(input logic [ALU_LEN-1:0] op);
        if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB))
            return 2'd0;
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            return 2'd1;
        else
            return 2'd3;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ALU_LEN-1:0] r_op;
    logic [RAM_AW-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [4:0]         r_rd_addr;
    logic               r_rd_en;
    logic [1:0]         r_idx;
    logic [31:0]        r_buf;

    logic               w_in_mem;
    logic               w_is_load;
    logic [1:0]         w_last;
    logic [1:0]         w_idx_m1;
    logic               w_accept;
    logic [31:0]        w_load_ext;
    logic               w_stall;
    logic               w_valid;
    logic [31:0]        w_rd_data;
    logic [4:0]         w_rd_addr;
    logic               w_rd_en;
    logic               w_ram_wr;
    logic [7:0]         w_ram_wdata;

    assign w_in_mem  = f_is_mem(alu_op_i);
    assign w_is_load = f_is_load(r_op);
    assign w_last    = f_last(r_op);
    assign w_idx_m1  = r_idx - 2'd1;

    always_comb begin
        w_load_ext = r_buf;
        if (r_op == OP_LB)
            w_load_ext = {{24{r_buf[7]}}, r_buf[7:0]};
        else if (r_op == OP_LBU)
            w_load_ext = {24'd0, r_buf[7:0]};
        else if (r_op == OP_LH)
            w_load_ext = {{16{r_buf[15]}}, r_buf[15:0]};
        else if (r_op == OP_LHU)
            w_load_ext = {16'd0, r_buf[15:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_stall     = 1'b0;
        w_valid     = 1'b0;
        w_rd_data   = 32'd0;
        w_rd_addr   = 5'd0;
        w_rd_en     = 1'b0;
        w_ram_wr    = 1'b0;
        w_ram_wdata = 8'd0;
        case (r_state)
            c_ST_IDLE: begin
                if (valid_i && w_in_mem) begin
                    w_stall = 1'b1;
                    if (rdy) begin
                        w_accept    = 1'b1;
                        w_state_nxt = c_ST_BUSY;
                    end
                end else begin
                    w_valid   = valid_i;
                    w_rd_data = rd_data_i;
                    w_rd_addr = rd_addr_i;
                    w_rd_en   = rd_enable_i;
                end
            end
            c_ST_BUSY: begin
                w_stall = 1'b1;
                if (!w_is_load) begin
                    w_ram_wr    = rdy;
                    w_ram_wdata = r_wdata[{r_idx, 3'b000} +: 8];
                end
                if (rdy && (r_idx == w_last))
                    w_state_nxt = w_is_load ? c_ST_WAIT : c_ST_DONE;
            end
            c_ST_WAIT: begin
                w_stall = 1'b1;
                if (rdy)
                    w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                w_valid   = 1'b1;
                w_rd_addr = r_rd_addr;
                if (w_is_load) begin
                    w_rd_en   = r_rd_en;
                    w_rd_data = w_load_ext;
                end
                if (rdy)
                    w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Read data lags its address by one enabled cycle, so BUSY stores the
    // previous byte and WAIT stores the final one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_rd_addr <= 5'd0;
            r_rd_en   <= 1'b0;
            r_idx     <= 2'd0;
            r_buf     <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op      <= alu_op_i;
                r_addr    <= mem_addr_i[RAM_AW-1:0];
                r_wdata   <= mem_wdata_i;
                r_rd_addr <= rd_addr_i;
                r_rd_en   <= rd_enable_i;
                r_idx     <= 2'd0;
                r_buf     <= 32'd0;
            end
            if (rdy && (r_state == c_ST_BUSY)) begin
                if (w_is_load && (r_idx != 2'd0))
                    r_buf[{w_idx_m1, 3'b000} +: 8] <= ram_rdata;
                if (r_idx != w_last)
                    r_idx <= r_idx + 2'd1;
            end
            if (rdy && (r_state == c_ST_WAIT))
                r_buf[{w_last, 3'b000} +: 8] <= ram_rdata;
        end
    end

    // Outputs are forced quiet while reset is held, including pass-through.
    assign ram_addr    = rst ? (r_addr + {{(RAM_AW-2){1'b0}}, r_idx}) : '0;
    assign ram_wdata   = rst ? w_ram_wdata : 8'd0;
    assign ram_wr      = rst & w_ram_wr;
    assign stall_o     = rst & w_stall;
    assign valid_o     = rst & w_valid;
    assign rd_data_o   = rst ? w_rd_data : 32'd0;
    assign rd_addr_o   = rst ? w_rd_addr : 5'd0;
    assign rd_enable_o = rst & w_rd_en;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Randomized self-checking bench for mem_access against a
//               transaction-level memory/result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam logic [4:0] c_OP_ADD = 5'd1;
    localparam logic [4:0] c_OP_LB  = 5'd10;
    localparam logic [4:0] c_OP_LH  = 5'd11;
    localparam logic [4:0] c_OP_LW  = 5'd12;
    localparam logic [4:0] c_OP_LBU = 5'd13;
    localparam logic [4:0] c_OP_LHU = 5'd14;
    localparam logic [4:0] c_OP_SB  = 5'd15;
    localparam logic [4:0] c_OP_SH  = 5'd16;
    localparam logic [4:0] c_OP_SW  = 5'd17;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        valid_i;
    logic [4:0]  alu_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_enable_i;
    logic [7:0]  ram_rdata = 8'h00;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wr;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_enable_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access #(
        .RAM_AW (32),     .ALU_LEN(5),
        .OP_LB  (c_OP_LB), .OP_LH (c_OP_LH), .OP_LW (c_OP_LW), .OP_LBU(c_OP_LBU),
        .OP_LHU (c_OP_LHU), .OP_SB(c_OP_SB), .OP_SH (c_OP_SH), .OP_SW (c_OP_SW)
    ) dut (
        .clk        (clk),        .rst        (rst),        .rdy        (rdy),
        .valid_i    (valid_i),    .alu_op_i   (alu_op_i),   .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .rd_data_i (rd_data_i),  .rd_addr_i  (rd_addr_i),
        .rd_enable_i(rd_enable_i), .ram_rdata (ram_rdata),  .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),  .ram_wr     (ram_wr),     .stall_o    (stall_o),
        .valid_o    (valid_o),    .rd_data_o  (rd_data_o),  .rd_addr_o  (rd_addr_o),
        .rd_enable_o(rd_enable_o)
    );

    // Test addresses live near 0 and near 2^32, folded into a small array.
    function automatic logic [10:0] ridx(input logic [31:0] a);
        return {a[31], a[9:0]};
    endfunction

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Byte-wide synchronous RAM; it only advances on enabled cycles.
    logic [7:0] ram [0:2047];
    logic       ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 2048; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (rst && rdy) begin
            if (ram_wr) ram[ridx(ram_addr)] <= ram_wdata;
            ram_rdata <= ram[ridx(ram_addr)];
        end
    end

    // Reference model state: the memory image as the program sees it.
    logic [7:0] ref_mem [0:2047];

    function automatic int nbytes(input logic [4:0] op);
        if (op == c_OP_LB || op == c_OP_LBU || op == c_OP_SB) return 1;
        if (op == c_OP_LH || op == c_OP_LHU || op == c_OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic is_load(input logic [4:0] op);
        return op inside {c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU};
    endfunction

    function automatic logic [31:0] extend(input logic [4:0] op, input logic [31:0] raw);
        case (op)
            c_OP_LB:  return 32'($signed(raw[7:0]));
            c_OP_LH:  return 32'($signed(raw[15:0]));
            c_OP_LBU: return {24'd0, raw[7:0]};
            c_OP_LHU: return {16'd0, raw[15:0]};
            default:  return raw;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_pass(input logic [4:0] op, input logic v, input logic [31:0] d,
                            input logic [4:0] rd, input logic en);
        valid_i = v; alu_op_i = op; rd_data_i = d; rd_addr_i = rd; rd_enable_i = en;
        mem_addr_i = $urandom; mem_wdata_i = $urandom;
        @(negedge clk);
        chk("pt_valid", valid_o, v);
        chk("pt_data", rd_data_o, d);
        chk("pt_addr", rd_addr_o, rd);
        chk("pt_en", rd_enable_o, en);
        chk("pt_stall", stall_o, 0);
        chk("pt_wr", ram_wr, 0);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rden,
                          input int frz_at, input int frz_len);
        int          n, base, stalls, wcnt, frz_left;
        logic        ld, done;
        logic [31:0] raw, expv;
        n    = nbytes(op);
        ld   = is_load(op);
        base = ld ? n + 2 : n + 1;
        raw  = 32'd0;
        for (int k = 0; k < n; k++) raw[8*k +: 8] = ref_mem[ridx(addr + 32'(k))];
        expv = ld ? extend(op, raw) : 32'd0;
        valid_i = 1'b1; alu_op_i = op; mem_addr_i = addr; mem_wdata_i = wd;
        rd_data_i = $urandom; rd_addr_i = rd; rd_enable_i = rden;
        stalls = 0; wcnt = 0; frz_left = 0; done = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (stall_o) begin
                stalls++;
                chk("busy_valid", valid_o, 0);
                if (!rdy) chk("frz_wr", ram_wr, 0);
                if (ram_wr) begin
                    chk("wr_addr", ram_addr, addr + 32'(wcnt));
                    chk("wr_data", ram_wdata, (wd >> (8 * wcnt)) & 32'hFF);
                    wcnt++;
                end
                @(posedge clk); #1;
                if (!rdy) begin
                    frz_left--;
                    if (frz_left == 0) rdy = 1'b1;
                end else if (frz_len > 0 && stalls == frz_at) begin
                    rdy = 1'b0;
                    frz_left = frz_len;
                end
            end else begin
                done = 1'b1;
                chk("done_valid", valid_o, 1);
                chk("rd_data", rd_data_o, expv);
                chk("rd_addr", rd_addr_o, rd);
                chk("rd_en", rd_enable_o, ld ? rden : 1'b0);
                chk("stalls", stalls, base + frz_len);
                chk("wr_count", wcnt, ld ? 0 : n);
            end
        end
        if (!done) chk("timeout", 0, 1);
        if (!ld) for (int k = 0; k < n; k++) ref_mem[ridx(addr + 32'(k))] = wd[8*k +: 8];
        @(posedge clk); #1;
        valid_i = 1'b0;
        rdy = 1'b1;
    endtask

    logic [4:0] ops [8] = '{c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU,
                            c_OP_LHU, c_OP_SB, c_OP_SH, c_OP_SW};

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(i);
        rst = 1'b0; rdy = 1'b1;
        valid_i = 1'b1; alu_op_i = c_OP_ADD; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        rd_data_i = 32'h1234; rd_addr_i = 5'd5; rd_enable_i = 1'b1;
        #3;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", rd_data_o, 0);
        chk("rst_en", rd_enable_o, 0);
        alu_op_i = c_OP_LW;
        #1;
        chk("rst_stall", stall_o, 0);
        chk("rst_wr", ram_wr, 0);
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run_pass(c_OP_ADD, 1'b1, 32'h1234, 5'd5, 1'b1);
        run_pass(c_OP_LW, 1'b0, 32'hCAFE0001, 5'd9, 1'b1);
        run_op(c_OP_SW, 32'h100, 32'hAABBCCDD, 5'd3, 1'b1, 0, 0);
        run_op(c_OP_SB, 32'h200, 32'h00000080, 5'd4, 1'b1, 0, 0);
        run_op(c_OP_LB, 32'h200, 32'h0, 5'd6, 1'b1, 0, 0);
        run_op(c_OP_LBU, 32'h200, 32'h0, 5'd7, 1'b1, 0, 0);
        run_op(c_OP_LW, 32'h100, 32'h0, 5'd8, 1'b1, 0, 0);
        run_op(c_OP_SB, 32'hFFFFFFFF, 32'h5A, 5'd1, 1'b0, 0, 0);
        run_op(c_OP_SB, 32'h0, 32'hC3, 5'd1, 1'b0, 0, 0);
        run_op(c_OP_LH, 32'hFFFFFFFF, 32'h0, 5'd10, 1'b1, 0, 0);
        run_op(c_OP_LW, 32'h100, 32'h0, 5'd11, 1'b1, 3, 3);

        // Reset in the middle of a word store: byte 0 lands, byte 1 does not.
        valid_i = 1'b1; alu_op_i = c_OP_SW; mem_addr_i = 32'h300;
        mem_wdata_i = 32'h11223344; rd_addr_i = 5'd2; rd_enable_i = 1'b1;
        @(negedge clk); chk("rs_accept", stall_o, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("rs_wr0", ram_wr, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("rs_wr1", ram_wr, 1);
        #1 rst = 1'b0; valid_i = 1'b0;
        #1;
        chk("rs_wr_off", ram_wr, 0);
        chk("rs_stall", stall_o, 0);
        chk("rs_valid", valid_o, 0);
        ref_mem[ridx(32'h300)] = 8'h44;
        @(posedge clk); #1;
        rst = 1'b1;
        run_op(c_OP_LW, 32'h300, 32'h0, 5'd12, 1'b1, 0, 0);

        for (int t = 0; t < 60; t++) begin
            logic [4:0]  op;
            logic [31:0] a;
            int          base;
            if ($urandom_range(0, 8) == 0) begin
                run_pass(5'($urandom_range(0, 9)), 1'($urandom), $urandom,
                         5'($urandom), 1'($urandom));
            end else begin
                op   = ops[$urandom_range(0, 7)];
                a    = ($urandom_range(0, 1) ? 32'hFFFFFFF0 : 32'h0) + 32'($urandom_range(0, 31));
                base = is_load(op) ? nbytes(op) + 2 : nbytes(op) + 1;
                if ($urandom_range(0, 3) == 0)
                    run_op(op, a, $urandom, 5'($urandom), 1'($urandom),
                           $urandom_range(1, base - 1), $urandom_range(1, 3));
                else
                    run_op(op, a, $urandom, 5'($urandom), 1'($urandom), 0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
